// File: rtl/branch_predictor_pkg.sv
// Shared types, default geometry and helpers for the fetch-side branch predictor.
package branch_predictor_pkg;

  localparam int BHT_INDEX_BITS = 4;
  localparam int BHT_TAG_BITS   = 8;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter with synchronous reset value and a direct load.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rst_value,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [1:0] load_value,
  output logic [1:0] ctr
);

  logic [1:0] ctr_reg;

  // Load wins over count so a fresh allocation starts from a known state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_reg <= rst_value;
    end else if (load) begin
      ctr_reg <= load_value;
    end else if (en) begin
      if (up && ctr_reg != CTR_ST) begin
        ctr_reg <= ctr_reg + 2'd1;
      end else if (!up && ctr_reg != CTR_SNT) begin
        ctr_reg <= ctr_reg - 2'd1;
      end
    end
  end

  assign ctr = ctr_reg;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with BTB, trained by the EX-stage comparator,
// plus mispredict/redirect generation and resolved/mispredicted branch counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BHT_INDEX_BITS,
  parameter int TAG_BITS   = BHT_TAG_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_reg;
  logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
  logic [31:0]         target_reg [ENTRIES];
  logic [1:0]          ctr        [ENTRIES];

  logic [31:0] branch_count_reg;
  logic [31:0] mispredict_count_reg;

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  if_hit;
  logic                  ex_hit;
  logic                  train;
  logic                  alloc;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign ex_tag = ex_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  assign if_hit = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign ex_hit = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);

  // Reads see pre-edge contents, so a same-index train is only visible next cycle.
  assign pred_taken  = if_hit && ctr[if_idx][1];
  assign pred_target = pred_taken ? target_reg[if_idx] : pc_plus4(if_pc);

  assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                    (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : pc_plus4(ex_pc);

  assign train = ex_valid && !rst;
  assign alloc = train && !ex_hit && ex_taken;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      logic sel;
      assign sel = (ex_idx == INDEX_BITS'(gi));

      sat_counter2 u_ctr (
        .clk        (clk),
        .rst        (rst),
        .rst_value  (CTR_WNT),
        .en         (train && ex_hit && sel),
        .up         (ex_taken),
        .load       (alloc && sel),
        .load_value (CTR_WT),
        .ctr        (ctr[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
      end
    end else if (ex_valid && ex_taken) begin
      // Taken branches always refresh the target; a miss also claims the entry.
      target_reg[ex_idx] <= ex_target;
      if (!ex_hit) begin
        valid_reg[ex_idx] <= 1'b1;
        tag_reg[ex_idx]   <= ex_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (ex_valid) branch_count_reg <= branch_count_reg + 32'd1;
      if (mispredict) mispredict_count_reg <= mispredict_count_reg + 32'd1;
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 = prediction, 1 = resolve, 2 = perf counters
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      case (e.kind)
        0: begin
          cmp({e.name, ".pred_taken"}, {31'd0, pred_taken}, e.a);
          cmp({e.name, ".pred_target"}, pred_target, e.b);
        end
        1: begin
          cmp({e.name, ".mispredict"}, {31'd0, mispredict}, e.a);
          cmp({e.name, ".redirect_pc"}, redirect_pc, e.b);
        end
        default: begin
          cmp({e.name, ".branch_count"}, branch_count, e.a);
          cmp({e.name, ".mispredict_count"}, mispredict_count, e.b);
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_pred(input string n, input logic t, input logic [31:0] tgt);
    sb.push_back('{n, 0, {31'd0, t}, tgt});
  endtask

  task automatic exp_res(input string n, input logic m, input logic [31:0] r);
    sb.push_back('{n, 1, {31'd0, m}, r});
  endtask

  task automatic exp_cnt(input string n, input logic [31:0] b, input logic [31:0] m);
    sb.push_back('{n, 2, b, m});
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = pc;
    ex_taken       = t;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst   = 1'b1;
    if_pc = 32'h100;
    idle();
    tick();
    exp_pred("in_reset", 1'b0, 32'h104);
    tick();
    rst = 1'b0;
    exp_pred("post_reset", 1'b0, 32'h104);
    exp_cnt("post_reset", 32'd0, 32'd0);
    exp_res("post_reset_idle", 1'b0, 32'h4);

    // First taken resolve allocates; prediction in the same cycle uses old state.
    tick();
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_res("alloc", 1'b1, 32'h80);
    exp_pred("alloc_no_bypass", 1'b0, 32'h104);
    tick();
    idle();
    exp_pred("after_alloc", 1'b1, 32'h80);
    exp_cnt("after_alloc", 32'd1, 32'd1);

    // Three more taken: 10 -> 11 -> 11 -> 11.
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      exp_res("taken_correct", 1'b0, 32'h80);
    end
    tick();
    idle();
    exp_cnt("after_taken3", 32'd4, 32'd1);

    // Two not-taken: 11 -> 10 -> 01.
    tick();
    drive_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    exp_res("nt1", 1'b1, 32'h104);
    tick();
    exp_res("nt2", 1'b1, 32'h104);
    exp_pred("nt2_still_taken", 1'b1, 32'h80);
    tick();
    idle();
    exp_pred("after_nt2", 1'b0, 32'h104);
    exp_cnt("after_nt2", 32'd6, 32'd3);

    // Two more not-taken saturate at 00; two taken then climb to 10.
    tick();
    drive_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    exp_res("nt3", 1'b0, 32'h104);
    tick();
    exp_res("nt4", 1'b0, 32'h104);
    tick();
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_res("up1", 1'b1, 32'h80);
    tick();
    idle();
    exp_pred("after_up1", 1'b0, 32'h104);
    tick();
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_res("up2", 1'b1, 32'h80);
    tick();
    idle();
    exp_pred("after_up2", 1'b1, 32'h80);
    exp_cnt("after_up2", 32'd10, 32'd5);

    // Aliasing: 0x140 shares index 0 with a different tag.
    tick();
    drive_ex(1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    exp_res("alias", 1'b1, 32'h200);
    tick();
    idle();
    exp_pred("alias_old_pc", 1'b0, 32'h104);
    tick();
    if_pc = 32'h140;
    exp_pred("alias_new_pc", 1'b1, 32'h200);

    // Reclaim 0x100, then retarget it.
    tick();
    if_pc = 32'h100;
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_res("realloc", 1'b1, 32'h80);
    tick();
    drive_ex(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    exp_res("retarget", 1'b1, 32'h90);
    tick();
    if_pc = 32'h103;
    drive_ex(1'b0, 32'hdead_beef, 1'b1, 32'h1234_5678, 1'b0, 32'h0bad_f00d);
    exp_pred("retarget_low_bits", 1'b1, 32'h90);
    exp_res("garbage_idle", 1'b0, 32'h1234_5678);
    exp_cnt("garbage_idle", 32'd13, 32'd8);
    tick();
    exp_cnt("garbage_idle2", 32'd13, 32'd8);

    // Reset wins over a concurrent taken resolve.
    tick();
    if_pc = 32'h100;
    rst   = 1'b1;
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_res("rst_with_ex", 1'b1, 32'h80);
    tick();
    rst = 1'b0;
    idle();
    exp_pred("after_rst_ex", 1'b0, 32'h104);
    exp_cnt("after_rst_ex", 32'd0, 32'd0);

    // PC+4 wrap at the top of the address space.
    tick();
    if_pc = 32'hffff_fffc;
    drive_ex(1'b1, 32'hffff_fffc, 1'b0, 32'h10, 1'b1, 32'h10);
    exp_pred("wrap_pred", 1'b0, 32'h0);
    exp_res("wrap_redirect", 1'b1, 32'h0);
    tick();
    idle();
    exp_cnt("wrap_cnt", 32'd1, 32'd1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
